// File: rtl/idli_sqi_ctrl_m.sv
// -----------------------------------------------------------------------------
// idli_pkg / idli_sqi_ctrl_m
//
// SQI memory controller for the idli core. It turns single-word read/write
// requests into the SQI serial-memory protocol: command, address, dummy (read
// only) and data phases, one nibble per clock. Sequential bursts continue with
// further 16-bit words, with no new command, while i_sqi_seq is held high.
//
// Ports
//   i_sqi_gck          core clock, rising edge
//   i_sqi_rst_n        asynchronous active-low reset
//   o_sqi_mem_sck      memory clock (equal to i_sqi_gck)
//   o_sqi_mem_cs       memory chip select, active-low, registered
//   o_sqi_mem_io_mode  SIO direction (SQI_IO_MODE_OUT / SQI_IO_MODE_IN), registered
//   i_sqi_mem_sio      nibble from memory
//   o_sqi_mem_sio      nibble to memory, registered
//   i_sqi_req          transfer request, held by the requester until accepted
//   i_sqi_req_wr       1 = write, 0 = read (qualified by i_sqi_req)
//   i_sqi_req_addr     start byte address (qualified by i_sqi_req)
//   o_sqi_req_acp      one-cycle accept pulse, in the same IDLE cycle as req
//   i_sqi_seq          continue the burst with another word
//   i_sqi_wr_data      write nibble, captured at the end of each wr_rdy cycle
//   o_sqi_wr_rdy       write nibble is consumed this cycle
//   o_sqi_rd_data      read nibble, registered
//   o_sqi_rd_vld       o_sqi_rd_data valid this cycle
//   o_sqi_busy         controller is not idle
// -----------------------------------------------------------------------------

package idli_pkg;
    localparam logic SQI_IO_MODE_OUT = 1'b0;
    localparam logic SQI_IO_MODE_IN  = 1'b1;
endpackage

module idli_sqi_ctrl_m
    import idli_pkg::*;
(
    input  logic        i_sqi_gck,
    input  logic        i_sqi_rst_n,
    output logic        o_sqi_mem_sck,
    output logic        o_sqi_mem_cs,
    output logic        o_sqi_mem_io_mode,
    input  logic [3:0]  i_sqi_mem_sio,
    output logic [3:0]  o_sqi_mem_sio,
    input  logic        i_sqi_req,
    input  logic        i_sqi_req_wr,
    input  logic [15:0] i_sqi_req_addr,
    output logic        o_sqi_req_acp,
    input  logic        i_sqi_seq,
    input  logic [3:0]  i_sqi_wr_data,
    output logic        o_sqi_wr_rdy,
    output logic [3:0]  o_sqi_rd_data,
    output logic        o_sqi_rd_vld,
    output logic        o_sqi_busy
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CMD   = 3'd1,
        ST_ADDR  = 3'd2,
        ST_DUMMY = 3'd3,
        ST_DATA  = 3'd4,
        ST_END   = 3'd5
    } state_t;

    state_t      state_r, state_s;
    logic [2:0]  step_r, step_s;
    logic [1:0]  nib_r, nib_s;
    logic        wr_r, wr_s;
    logic [15:0] addr_r, addr_s;
    logic        cs_r, cs_s;
    logic        io_mode_r, io_mode_s;
    logic [3:0]  sio_r, sio_s;
    logic        acp_s;
    logic        wr_rdy_s;
    logic [3:0]  rd_data_r;
    logic        rd_vld_r;

    // Next-state, counters and the pin values for the next cycle. The pin
    // values are computed from the state being entered so that, once
    // registered, they line up with the cycle that state occupies.
    always_comb begin
        state_s   = state_r;
        step_s    = step_r;
        nib_s     = nib_r;
        wr_s      = wr_r;
        addr_s    = addr_r;
        cs_s      = 1'b1;
        io_mode_s = SQI_IO_MODE_OUT;
        sio_s     = 4'h0;
        acp_s     = 1'b0;
        wr_rdy_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // Accept is combinational so req and acp share the IDLE
                // cycle; it is masked while reset is asserted.
                if (i_sqi_req && i_sqi_rst_n) begin
                    acp_s   = 1'b1;
                    wr_s    = i_sqi_req_wr;
                    addr_s  = i_sqi_req_addr;
                    state_s = ST_CMD;
                    step_s  = 3'd0;
                    cs_s    = 1'b0;
                    sio_s   = 4'h0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CMD: begin
                cs_s = 1'b0;
                if (step_r == 3'd0) begin
                    step_s = 3'd1;
                    if (wr_r) begin
                        sio_s = 4'h2;
                    end else begin
                        sio_s = 4'h3;
                    end
                end else begin
                    state_s = ST_ADDR;
                    step_s  = 3'd0;
                    sio_s   = addr_r[15:12];
                end
            end
            ST_ADDR: begin
                cs_s   = 1'b0;
                step_s = step_r + 3'd1;
                case (step_r)
                    3'd0: sio_s = addr_r[11:8];
                    3'd1: sio_s = addr_r[7:4];
                    3'd2: sio_s = addr_r[3:0];
                    3'd3: begin
                        step_s = 3'd0;
                        nib_s  = 2'd0;
                        if (wr_r) begin
                            // First data nibble is taken in the last address cycle.
                            state_s  = ST_DATA;
                            wr_rdy_s = 1'b1;
                            sio_s    = i_sqi_wr_data;
                        end else begin
                            state_s   = ST_DUMMY;
                            io_mode_s = SQI_IO_MODE_IN;
                        end
                    end
                    default: begin
                        state_s = ST_IDLE;
                        cs_s    = 1'b1;
                    end
                endcase
            end
            ST_DUMMY: begin
                cs_s      = 1'b0;
                io_mode_s = SQI_IO_MODE_IN;
                if (step_r == 3'd0) begin
                    step_s = 3'd1;
                end else begin
                    state_s = ST_DATA;
                    step_s  = 3'd0;
                    nib_s   = 2'd0;
                end
            end
            ST_DATA: begin
                cs_s  = 1'b0;
                nib_s = nib_r + 2'd1;
                if (wr_r) begin
                    // At the word boundary another nibble is wanted only
                    // if the burst continues.
                    wr_rdy_s = (nib_r != 2'd3) | i_sqi_seq;
                end else begin
                    io_mode_s = SQI_IO_MODE_IN;
                end
                if (wr_rdy_s) begin
                    sio_s = i_sqi_wr_data;
                end else begin
                    sio_s = 4'h0;
                end
                if ((nib_r == 2'd3) && !i_sqi_seq) begin
                    state_s   = ST_END;
                    cs_s      = 1'b1;
                    io_mode_s = SQI_IO_MODE_OUT;
                end else begin
                    state_s = ST_DATA;
                end
            end
            ST_END: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Control state, counters and captured request.
    always_ff @(posedge i_sqi_gck or negedge i_sqi_rst_n) begin
        if (!i_sqi_rst_n) begin
            state_r <= ST_IDLE;
            step_r  <= 3'd0;
            nib_r   <= 2'd0;
            wr_r    <= 1'b0;
            addr_r  <= 16'h0000;
        end else begin
            state_r <= state_s;
            step_r  <= step_s;
            nib_r   <= nib_s;
            wr_r    <= wr_s;
            addr_r  <= addr_s;
        end
    end

    // Registered memory pins; reset raises CS at once without an END cycle.
    always_ff @(posedge i_sqi_gck or negedge i_sqi_rst_n) begin
        if (!i_sqi_rst_n) begin
            cs_r      <= 1'b1;
            io_mode_r <= SQI_IO_MODE_OUT;
            sio_r     <= 4'h0;
        end else begin
            cs_r      <= cs_s;
            io_mode_r <= io_mode_s;
            sio_r     <= sio_s;
        end
    end

    // Read capture: each data-phase nibble is presented the following cycle.
    always_ff @(posedge i_sqi_gck or negedge i_sqi_rst_n) begin
        if (!i_sqi_rst_n) begin
            rd_data_r <= 4'h0;
            rd_vld_r  <= 1'b0;
        end else if ((state_r == ST_DATA) && !wr_r) begin
            rd_data_r <= i_sqi_mem_sio;
            rd_vld_r  <= 1'b1;
        end else begin
            rd_vld_r  <= 1'b0;
        end
    end

    assign o_sqi_mem_sck     = i_sqi_gck;
    assign o_sqi_mem_cs      = cs_r;
    assign o_sqi_mem_io_mode = io_mode_r;
    assign o_sqi_mem_sio     = sio_r;
    assign o_sqi_req_acp     = acp_s;
    assign o_sqi_wr_rdy      = wr_rdy_s;
    assign o_sqi_rd_data     = rd_data_r;
    assign o_sqi_rd_vld      = rd_vld_r;
    assign o_sqi_busy        = (state_r != ST_IDLE);

endmodule
